// File: rtl/md_unit_pkg.sv
// md_unit shared definitions: md_op encodings, FSM states, default latencies.
// Also used by the D-stage hazard unit to classify MD-class instructions.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_STATE_IDLE = 1'b0,
    MD_STATE_BUSY = 1'b1
  } md_state_e;

  localparam int MD_WIDTH       = 32;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == 3'(MD_DIV)) || (op == 3'(MD_DIVU));
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit pipeline interface: E-stage request (start/md_op/src_a/src_b/rd_sel)
// and unit status (busy, rd_data, hi, lo). master = pipeline, slave = unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_sel;
  logic             busy;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, src_a, src_b, rd_sel,
    input  busy, rd_data, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, rd_sel,
    output busy, rd_data, hi, lo
  );
endinterface

// File: rtl/md_unit_calc.sv
// md_calc: combinational mult/multu/div/divu on magnitudes with sign fix-up.
// Ports: op_i, a_i, b_i in; hi_o, lo_o, we_o (0 on div-by-zero/non-arith) out.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             we_o
);
  localparam int W2 = 2 * WIDTH;

  logic             sgn, a_neg, b_neg, is_mul, is_div;
  logic [WIDTH-1:0] a_mag, b_mag, b_div;
  logic [WIDTH-1:0] q_mag, r_mag, q, r;
  logic [W2-1:0]    prod_u, prod;

  assign sgn    = (op_i == 3'(MD_MULT)) || (op_i == 3'(MD_DIV));
  assign is_mul = (op_i == 3'(MD_MULT)) || (op_i == 3'(MD_MULTU));
  assign is_div = md_is_div(op_i);
  assign a_neg  = sgn & a_i[WIDTH-1];
  assign b_neg  = sgn & b_i[WIDTH-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;

  assign prod_u = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign prod   = (a_neg ^ b_neg) ? -prod_u : prod_u;

  // Divisor forced to 1 on zero so the divider never sees X; result dropped.
  // MIN/-1 lands on 0x80..0 / 0 naturally: |MIN| is still MIN unsigned.
  assign b_div  = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_div;
  assign r_mag  = a_mag % b_div;
  assign q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r      = a_neg ? -r_mag : r_mag;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    we_o = 1'b0;
    unique case (1'b1)
      is_mul: begin
        {hi_o, lo_o} = prod;
        we_o         = 1'b1;
      end
      is_div: begin
        hi_o = r;
        lo_o = q;
        we_o = (b_i != '0);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide with HI/LO state and multi-cycle busy.
// Ports: clk, reset (sync, active-high), md (md_unit_if.slave).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = MD_WIDTH,
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;

  logic [WIDTH-1:0] c_hi, c_lo;
  logic             c_we;
  logic             idle, accept, wr_hi, wr_lo, done, count;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (c_hi),
    .lo_o (c_lo),
    .we_o (c_we)
  );

  assign idle   = (state_q == MD_STATE_IDLE);
  assign accept = idle & md.start & md_is_arith(md.md_op);
  assign wr_hi  = idle & ~md.start & (md.md_op == 3'(MD_MTHI));
  assign wr_lo  = idle & ~md.start & (md.md_op == 3'(MD_MTLO));
  assign done   = ~idle & (cnt_q == CW'(1));
  assign count  = ~idle & (cnt_q != CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (1'b1)
      accept: begin
        state_d = MD_STATE_BUSY;
        cnt_d   = md_is_div(md.md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        a_d     = md.src_a;
        b_d     = md.src_b;
        op_d    = md.md_op;
      end
      wr_hi: hi_d = md.src_a;
      wr_lo: lo_d = md.src_a;
      count: cnt_d = cnt_q - CW'(1);
      done: begin
        state_d = MD_STATE_IDLE;
        cnt_d   = '0;
        if (c_we) begin
          hi_d = c_hi;
          lo_d = c_lo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_STATE_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign md.busy    = ~idle;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.rd_data = md.rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed + random checks of md_unit against an arithmetic model.
// Drives and samples on the falling edge.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) mif();

  md_unit #(
    .WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] hi_m, lo_m;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op, input logic [31:0] a,
                                input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      1: begin p = sa * sb; {hi_m, lo_m} = p; end
      2: begin pu = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = pu; end
      3: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      5: hi_m = a;
      6: lo_m = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input int op, input logic [31:0] a,
                        input logic [31:0] b, input logic sel);
    int n;
    logic [31:0] oh, ol;
    n  = (op >= 3) ? 10 : 5;
    oh = hi_m;
    ol = lo_m;
    mif.start = 1'b1;
    mif.md_op = 3'(op);
    mif.src_a = a;
    mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    model(op, a, b);
    for (int k = 0; k < n; k++) begin
      check({tag, " busy"}, {31'b0, mif.busy}, 32'd1);
      check({tag, " hi early"}, mif.hi, oh);
      check({tag, " lo early"}, mif.lo, ol);
      @(negedge clk);
    end
    mif.rd_sel = sel;
    #1;
    check({tag, " busy end"}, {31'b0, mif.busy}, 32'd0);
    check({tag, " hi"}, mif.hi, hi_m);
    check({tag, " lo"}, mif.lo, lo_m);
    check({tag, " rd_data"}, mif.rd_data, sel ? hi_m : lo_m);
  endtask

  task automatic mt(input string tag, input int op, input logic [31:0] a);
    mif.start = 1'b0;
    mif.md_op = 3'(op);
    mif.src_a = a;
    @(negedge clk);
    mif.md_op = 3'd0;
    model(op, a, 32'd0);
    check({tag, " busy"}, {31'b0, mif.busy}, 32'd0);
    check({tag, " hi"}, mif.hi, hi_m);
    check({tag, " lo"}, mif.lo, lo_m);
  endtask

  initial begin
    int op;
    logic [31:0] a, b;
    reset      = 1'b1;
    mif.start  = 1'b0;
    mif.md_op  = 3'd0;
    mif.src_a  = '0;
    mif.src_b  = '0;
    mif.rd_sel = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("reset busy", {31'b0, mif.busy}, 32'd0);
    check("reset hi", mif.hi, 32'd0);
    check("reset lo", mif.lo, 32'd0);
    check("reset rd_data", mif.rd_data, 32'd0);

    run_op("mult -2*3", 1, 32'hFFFFFFFE, 32'd3, 1'b1);
    check("mult -2*3 hi const", mif.hi, 32'hFFFFFFFF);
    check("mult -2*3 lo const", mif.lo, 32'hFFFFFFFA);
    check("mult -2*3 rd const", mif.rd_data, 32'hFFFFFFFF);

    run_op("multu", 2, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu hi const", mif.hi, 32'd1);
    check("multu lo const", mif.lo, 32'hFFFFFFFE);
    run_op("mult same", 1, 32'hFFFFFFFF, 32'd2, 1'b1);
    check("mult same hi const", mif.hi, 32'hFFFFFFFF);
    check("mult same lo const", mif.lo, 32'hFFFFFFFE);

    run_op("div -7/2", 3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div -7/2 lo const", mif.lo, 32'hFFFFFFFD);
    check("div -7/2 hi const", mif.hi, 32'hFFFFFFFF);
    run_op("divu 7/2", 4, 32'd7, 32'd2, 1'b1);
    check("divu lo const", mif.lo, 32'd3);
    check("divu hi const", mif.hi, 32'd1);
    run_op("div ovf", 3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div ovf lo const", mif.lo, 32'h80000000);
    check("div ovf hi const", mif.hi, 32'd0);

    mt("mthi", 5, 32'h11);
    mt("mtlo", 6, 32'h22);
    run_op("div by 0", 3, 32'd1234, 32'd0, 1'b1);
    check("div0 hi const", mif.hi, 32'h11);
    check("div0 lo const", mif.lo, 32'h22);

    // start with non-arith op codes does nothing
    mif.start = 1'b1;
    mif.md_op = 3'd7;
    mif.src_a = 32'hDEAD;
    @(negedge clk);
    mif.md_op = 3'd5;
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    check("start op7/5 busy", {31'b0, mif.busy}, 32'd0);
    check("start op7/5 hi", mif.hi, 32'h11);
    check("start op7/5 lo", mif.lo, 32'h22);

    // mthi and a second start issued while busy are both dropped
    mif.start = 1'b1;
    mif.md_op = 3'd1;
    mif.src_a = 32'd3;
    mif.src_b = 32'd4;
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    check("ign c1 busy", {31'b0, mif.busy}, 32'd1);
    @(negedge clk);
    mif.md_op = 3'd5;
    mif.src_a = 32'hAA;
    check("ign c2 busy", {31'b0, mif.busy}, 32'd1);
    @(negedge clk);
    mif.start = 1'b1;
    mif.md_op = 3'd1;
    mif.src_a = 32'd9;
    mif.src_b = 32'd9;
    check("ign c3 busy", {31'b0, mif.busy}, 32'd1);
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    check("ign c4 busy", {31'b0, mif.busy}, 32'd1);
    @(negedge clk);
    check("ign c5 busy", {31'b0, mif.busy}, 32'd1);
    @(negedge clk);
    model(1, 32'd3, 32'd4);
    check("ign end busy", {31'b0, mif.busy}, 32'd0);
    check("ign hi", mif.hi, 32'd0);
    check("ign lo", mif.lo, 32'd12);

    // reset while busy aborts and clears HI/LO
    mt("mthi pre-rst", 5, 32'h55);
    mif.start = 1'b1;
    mif.md_op = 3'd4;
    mif.src_a = 32'd100;
    mif.src_b = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    repeat (3) @(negedge clk);
    check("rst c4 busy", {31'b0, mif.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    check("rst busy", {31'b0, mif.busy}, 32'd0);
    check("rst hi", mif.hi, 32'd0);
    check("rst lo", mif.lo, 32'd0);
    repeat (12) @(negedge clk);
    check("rst no late hi", mif.hi, 32'd0);
    check("rst no late lo", mif.lo, 32'd0);
    run_op("mult 2*3", 1, 32'd2, 32'd3, 1'b0);
    check("mult 2*3 lo const", mif.lo, 32'd6);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      if (op <= 4) run_op("rand op", op, a, b, 1'($urandom_range(0, 1)));
      else         mt("rand mt", op, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit with architectural HI/LO registers, instantiated in the E stage of the 5-stage MIPS pipeline.
- Supports mult/multu/div/divu with parametrised multi-cycle latency, plus mthi/mtlo writes and mfhi/mflo reads.
- Exports `busy` so the D-stage hazard logic stalls any MD-class instruction while an operation is in flight.
- Adds real multi-cycle operations and HI/LO architectural state to the pipeline.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10: busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is mult/multu/div/divu; sampled at posedge.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved and treated as none.
- src_a  input  WIDTH  forwarded GRF[rs].
- src_b  input  WIDTH  forwarded GRF[rt].
- rd_sel  input  1  0 selects LO, 1 selects HI for mfhi/mflo.
- busy  output  1  operation in flight.
- rd_data  output  WIDTH  combinational HI or LO per rd_sel.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port named reset.
- Reset values: hi=0, lo=0, busy=0, state IDLE, counter 0. Reset mid-operation aborts the operation, discards its result, and lands HI/LO=0 on the next edge.
- States and transitions:
  - IDLE -> BUSY on accept.
  - BUSY -> IDLE when counter reaches 1.
- Accept: edge with state IDLE, start=1, and md_op in 1..4.
  - At accept, latch operands and md_op into the result/pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- Cycle timing:
  - busy=1 for exactly N cycles after the accepting edge.
  - HI/LO update on the edge where busy falls (the Nth edge after accept).
  - New HI/LO are visible on the first cycle with busy=0.
- start=1 while BUSY is ignored; the hazard unit guarantees it never happens. The bench asserts on it.
- start=1 with md_op outside 1..4 is ignored.
- mthi/mtlo:
  - With start=0 and md_op=5/6 in IDLE, HI or LO := src_a on that edge, single cycle, no busy.
  - While BUSY they are ignored (the hazard unit stalls them).
- Arithmetic:
  - mult: {HI,LO} = signed(src_a) * signed(src_b), 2*WIDTH-bit product.
  - multu: same, unsigned.
  - div: LO = quotient, HI = remainder, truncate toward zero; remainder takes the dividend's sign.
  - divu: same, unsigned.
  - Divide by zero: HI/LO unchanged after the latency; busy still asserted N cycles.
  - Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80000000, HI = 0.
- rd_data is purely combinational from the registers; it is not bypassed from the in-flight result. The hazard unit stalls mfhi/mflo while busy or start.
- The result may be computed at accept (behavioural) or iteratively. It must never become visible early on hi/lo.

Decomposition:
- Shared package holds:
  - md_op encodings MD_NONE..MD_MTLO.
  - MD_STATE_IDLE/BUSY constants.
  - Default latency constants.
- The package is reused by the D-stage hazard unit to decode MD-class instructions.
- One sub-module: md_calc. Combinational signed/unsigned multiply and divide with the div-by-zero flag and overflow rule, returning {hi_next, lo_next, valid_write}.
- md_unit owns the FSM, counter, and HI/LO registers.

Test Plan:
- mult: reset, then start with mult, src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; rd_sel=1 -> rd_data=0xFFFFFFFF.
- multu vs mult: multu 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE; mult on the same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Signed and unsigned divide:
  - div -7/2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 -> LO=3, HI=1.
  - div 0x80000000/-1 -> LO=0x80000000, HI=0.
- Divide by zero: mthi 0x11, mtlo 0x22, then div x/0 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Ignored writes during busy: start mult 3*4; assert mthi src_a=0xAA on cycle 2 of busy, plus a spurious start -> ignored; after 5 cycles HI=0, LO=12, and the counter is not restarted.
- Reset mid-operation: start divu 100/7; assert reset on busy cycle 4 -> next cycle busy=0, HI=LO=0; a later mult 2*3 gives LO=6 after 5 cycles.
